mem_port_arbiter: RTL

- Shares the CPU's single memory port between two requesters: instruction fetch (F) and load/store data (D).
- Uses a registered req/grant handshake, holds exactly one outstanding memory transaction at a time, and waits for the memory to signal completion.
- D has priority over F. A streak counter guarantees F progress.
- Sits between logic_control / address register and the external memory interface.

---
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Summary  : Shares one memory port between fetch (F) and data (D) requesters.
//            D wins ties; a streak limit forces F after MAX_D_STREAK D grants.
//            Optional watchdog abort is enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_error
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  generate
    if (MAX_D_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mem_port_arbiter: MAX_D_STREAK and TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  logic                f_gnt_q, f_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                f_valid_q, f_valid_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                streak_full;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
`endif

  assign streak_full = (d_streak_q == STREAK_W'(MAX_D_STREAK));

  always_comb begin
    state_d     = state_q;
    d_streak_d  = d_streak_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_valid_d   = 1'b0;
    d_done_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // D yields only when F is waiting and D has used up its streak.
        if (d_req && !(f_req && streak_full)) begin
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          state_d     = D_BUSY;
          if (!f_req) begin
            d_streak_d = '0;
          end else if (!streak_full) begin
            d_streak_d = d_streak_q + STREAK_W'(1);
          end
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end else if (f_req) begin
          f_gnt_d    = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = f_addr;
          mem_we_d   = 1'b0;
          state_d    = F_BUSY;
          d_streak_d = '0;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      F_BUSY, D_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
          if (state_q == F_BUSY) begin
            f_rdata_d = mem_rdata;
            f_valid_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog abort: complete the transaction with zero data and flag it.
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_error_d = 1'b1;
          state_d     = IDLE;
          if (state_q == F_BUSY) begin
            f_rdata_d = '0;
            f_valid_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_done_d  = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      d_streak_q  <= '0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_valid_q   <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      d_streak_q  <= d_streak_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_valid_q   <= f_valid_d;
      d_done_q    <= d_done_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
`endif
    end
  end

  assign f_gnt        = f_gnt_q;
  assign d_gnt        = d_gnt_q;
  assign f_valid      = f_valid_q;
  assign d_done       = d_done_q;
  assign f_rdata      = f_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_write_en = mem_we_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_error    = mem_error_q;
`else
  assign mem_error    = 1'b0;
`endif

endmodule

`default_nettype wire
